// File: rtl/uart_core_v2.sv
// uart_core_v2: parameterised full-duplex UART, valid/ready on both sides,
// oversampled majority-voted receiver with parity, framing and overrun reporting.
module uart_core_v2 #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  input  logic                 rx_serial,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int TD = (CLK_FREQ / (BAUD_RATE * OVERSAMPLE)) < 1 ? 1 : CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int BIT_CYCLES = TD * OVERSAMPLE;
  localparam int STOP_CYCLES = STOP_BITS * BIT_CYCLES;
  localparam int CW = $clog2(STOP_CYCLES) + 1;
  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam int TW = $clog2(TD) + 1;
  localparam int SW = $clog2(OVERSAMPLE) + 1;
  localparam logic [CW-1:0] BIT_END = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_END = IW'(DATA_BITS - 1);
  localparam logic [TW-1:0] TICK_END = TW'(TD - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic ODD = PARITY == 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t tx_st, tx_nx;
  logic [CW-1:0] tx_cnt;
  logic [IW-1:0] tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic tx_par, tx_end;

  assign tx_end = tx_cnt == (tx_st == STOP ? STOP_END : BIT_END);
  assign tx_ready = tx_st == IDLE;
  assign tx_serial = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PAR ? tx_par : 1'b1;

  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      IDLE:    tx_nx = tx_valid ? START : IDLE;
      START:   tx_nx = tx_end ? DATA : START;
      DATA:    tx_nx = tx_end && tx_idx == IDX_END ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     tx_nx = tx_end ? STOP : PAR;
      STOP:    tx_nx = tx_end ? IDLE : STOP;
      default: tx_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      tx_cnt <= tx_st == IDLE || tx_end ? '0 : tx_cnt + 1'b1;
      if (tx_st == IDLE && tx_valid) begin
        tx_sh <= tx_data;
        tx_par <= (^tx_data) ^ ODD;
      end
      if (tx_st == DATA && tx_end) begin
        tx_sh <= tx_sh >> 1;
        tx_idx <= tx_idx + 1'b1;
      end
      if (tx_st != DATA) tx_idx <= '0;
    end
  end

  state_t rx_st, rx_nx;
  logic s1, s2, s3;
  logic [TW-1:0] tdiv;
  logic [SW-1:0] scnt;
  logic [IW-1:0] rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic v0, v1, perr;
  logic tick, detect, smp, bit_end, maj, done;

  // s3 is the previous synchronized sample, used only for falling-edge start detection
  assign tick = tdiv == TICK_END;
  assign detect = rx_st == IDLE && s3 && !s2;
  assign smp = tick && scnt == S_MID + 1'b1;
  assign bit_end = tick && scnt == S_END;
  assign maj = (v0 & v1) | (v0 & s2) | (v1 & s2);
  assign done = rx_st == STOP && smp;

  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:      rx_nx = detect ? START : IDLE;
      START:     rx_nx = smp && maj ? IDLE : bit_end ? DATA : START;
      DATA:      rx_nx = bit_end && rx_idx == IDX_END ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:       rx_nx = bit_end ? STOP : PAR;
      STOP:      rx_nx = smp ? (maj ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: rx_nx = s2 ? IDLE : WAIT_HIGH;
      default:   rx_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= IDLE;
      {s3, s2, s1} <= 3'b111;
      tdiv <= '0;
      scnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      perr <= 1'b0;
    end else begin
      rx_st <= rx_nx;
      {s3, s2, s1} <= {s2, s1, rx_serial};
      tdiv <= detect || tick ? '0 : tdiv + 1'b1;
      scnt <= detect ? '0 : tick ? (scnt == S_END ? '0 : scnt + 1'b1) : scnt;
      if (tick && scnt == S_MID - 1'b1) v0 <= s2;
      if (tick && scnt == S_MID) v1 <= s2;
      if (rx_st == DATA && smp) rx_sh <= {maj, rx_sh[DATA_BITS-1:1]};
      if (rx_st == DATA && bit_end) rx_idx <= rx_idx + 1'b1;
      if (rx_st != DATA) rx_idx <= '0;
      if (detect) perr <= 1'b0;
      if (rx_st == PAR && smp) perr <= maj ^ (^rx_sh) ^ ODD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_valid <= 1'b1;
        rx_data <= rx_sh;
        rx_parity_err <= perr;
        rx_frame_err <= !maj;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_core_v2.md
# uart_core_v2

Parameterised full-duplex UART with configurable frame format (data width, parity, stop bits) and valid/ready handshakes on both directions. The receiver uses an oversampled, majority-voted front end with a synchronizer, and reports parity, framing and overrun errors. It replaces the fixed 8N1 UART as the host-serial endpoint feeding the image-reader control path.

## Interface
- CLK_FREQ, 125000000: system clock frequency, Hz.
- BAUD_RATE, 115200: line rate, bit/s.
- OVERSAMPLE, 16: RX ticks per bit; even, ≥ 8.
- DATA_BITS, 8: payload width, 5–9. Sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

- clk  in  1  System clock. Only clock.
- rst  in  1  Reset. Synchronous, active-high.
- tx_valid  in  1  TX word offered.
- tx_ready  out  1  TX can accept a word.
- tx_data  in  DATA_BITS  Word to send.
- tx_serial  out  1  Serial output, idle high.
- rx_serial  in  1  Serial input. Asynchronous.
- rx_valid  out  1  Received word held.
- rx_ready  in  1  Consumer accepts the held word.
- rx_data  out  DATA_BITS  Received word.
- rx_parity_err  out  1  Parity mismatch on the held word. Always 0 when PARITY = 0.
- rx_frame_err  out  1  First stop bit was sampled low on the held word.
- rx_overrun  out  1  One-cycle pulse: a completed frame was dropped.

## Operation
- Derived constants:
  - TICK_DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer floor, ≥ 1.
  - BIT_CYCLES = TICK_DIV*OVERSAMPLE.
  - FRAME_BITS = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
  - Counter widths are $clog2 of their terminal value + 1. No wrap occurs inside a frame.
- TX FSM: IDLE → START → DATA → PARITY (skipped if PARITY = 0) → STOP → IDLE.
  - tx_ready = 1 only in IDLE.
  - A transfer occurs when tx_valid && tx_ready; tx_data is latched at that point.
  - Each state holds its bit for exactly BIT_CYCLES cycles. A local cycle counter is cleared at acceptance.
  - The STOP state lasts STOP_BITS*BIT_CYCLES cycles.
  - Parity bit = XOR of the data bits, inverted for odd parity.
- RX front end:
  - rx_serial passes through a 2-FF synchronizer.
  - An oversample tick is generated every TICK_DIV cycles. The tick counter is cleared when a start edge is detected.
- RX FSM: IDLE → START → DATA → PARITY (if enabled) → STOP → IDLE/WAIT_HIGH.
  - Start detect: the synchronized line goes 1 → 0 while in IDLE.
  - Each bit value is the majority of three samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within that bit.
  - False start: if the start-bit majority is 1, return to IDLE with no output.
  - Only the first stop bit is sampled. Any second stop bit is not checked.
  - Stop majority = 0: set frame_err and go to WAIT_HIGH. Stay there until the synchronized line is 1, then go to IDLE. This covers break conditions.
- RX holding register:
  - Frame complete and rx_valid = 0: load rx_data and both error flags, set rx_valid.
  - Frame complete and rx_valid = 1: keep the old word, pulse rx_overrun, discard the new frame.
  - rx_valid && rx_ready: clear rx_valid. A completion in the same cycle loads the new frame and leaves rx_valid = 1, with no overrun.
- Error flags are valid only while rx_valid = 1. They are never sticky across words.

## Timing
- Reset values:
  - tx_serial = 1, tx_ready = 1.
  - rx_valid = 0, rx_data = 0, rx_parity_err = 0, rx_frame_err = 0, rx_overrun = 0.
  - Both FSMs in IDLE; all counters 0.
- Reset mid-frame: any in-flight frame is abandoned. tx_serial = 1 in the cycle after rst is sampled high.
- TX latency and throughput:
  - Handshake at edge N: tx_serial = 0 from N+1.
  - tx_ready returns to 1 at N+1+FRAME_BITS*BIT_CYCLES.
  - Back-to-back transfers therefore need no idle gap beyond the stop bits.
- RX latency: rx_valid rises one cycle after the tick that takes the third stop-bit sample. The synchronizer adds 2 cycles to the line-to-detect delay.
- rx_ready is ignored while rx_valid = 0.
- tx_valid may be held high continuously; each word is sent exactly once per handshake.

## Test plan
Simulation parameters: CLK_FREQ = 16000000, BAUD_RATE = 1000000, OVERSAMPLE = 16. This gives TICK_DIV = 1 and BIT_CYCLES = 16.

- TX 8N1: send tx_data = 0xA5 → tx_serial carries 0, 1,0,1,0,0,1,0,1, 1, 16 cycles per bit. tx_ready is low for exactly 160 cycles.
- TX 7E2 (DATA_BITS = 7, PARITY = 2, STOP_BITS = 2): send 0x35 → data bits 1,0,1,0,1,1,0, then parity 0, then 32 cycles of high. tx_ready is low for 176 cycles.
- Loopback, 8O1, tx_serial tied to rx_serial: words 0x00, 0xFF, 0x5A → rx_valid rises once per word with matching rx_data and both error flags 0.
- Error injection:
  - Drive a frame for 0x3C with the parity bit flipped → rx_parity_err = 1.
  - Drive a frame with the stop bit low, then hold the line low for 40 cycles → rx_frame_err = 1, and no new start is detected until the line returns high.
- Glitch and overrun:
  - A 6-cycle low pulse on rx_serial → no rx_valid.
  - Two frames, 0x11 then 0x22, with rx_ready held low → rx_data stays 0x11 and rx_overrun pulses exactly once.
- Reset mid-frame: assert rst during TX data bit 3 → tx_serial = 1 and tx_ready = 1 on the next cycle. A following send of 0x81 completes correctly.
